// File: rtl/vce2_vseq.sv
// vce2_vseq: element-loop sequencer driving AGU strobes and one outstanding memory access per operand.
// Optional VCE2_VSEQ_SCALAR_OPB_EN replaces the rs2 read with a scalar operand captured at start.
module vce2_vseq #(
    parameter int DataWidth = 32,
    parameter int VlWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [VlWidth-1:0]   vl_i,
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
    input  logic [DataWidth-1:0] scalar_i,
    input  logic                 use_scalar_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 agu_load_o,
    input  logic                 agu_ready_i,
    output logic                 agu_get_rs1_o,
    output logic                 agu_get_rs2_o,
    output logic                 agu_get_rd_o,
    output logic                 agu_get_rd_noincr_o,
    input  logic                 mem_ready_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic [DataWidth-1:0] alu_op_a_o,
    output logic [DataWidth-1:0] alu_op_b_o,
    input  logic [DataWidth-1:0] alu_result_i
);
    typedef enum logic [2:0] {IDLE, SETUP, RS1, RS1_W, RS2, RS2_W, WB, DONE} state_t;
    state_t state, state_nxt;
    logic [VlWidth-1:0] vl_q, cnt, cnt_inc;
    logic use_scalar_q;
    assign cnt_inc = cnt + 1'b1;
    assign agu_get_rd_noincr_o = 1'b0;
`ifndef VCE2_VSEQ_SCALAR_OPB_EN
    assign use_scalar_q = 1'b0;
`endif
    // Strobes and requests are gated by mem_ready_i so each AGU counter moves only on an accepted issue.
    always_comb begin
        state_nxt = state;
        busy_o = state != IDLE;
        done_o = state == DONE;
        agu_load_o = 1'b0;
        agu_get_rs1_o = 1'b0;
        agu_get_rs2_o = 1'b0;
        agu_get_rd_o = 1'b0;
        mem_req_o = 1'b0;
        mem_we_o = 1'b0;
        mem_wdata_o = '0;
        case (state)
            IDLE: begin
                agu_load_o = start_i;
                state_nxt = start_i ? SETUP : IDLE;
            end
            SETUP: state_nxt = agu_ready_i ? ((vl_q == '0) ? DONE : RS1) : SETUP;
            RS1: begin
                mem_req_o = mem_ready_i;
                agu_get_rs1_o = mem_ready_i;
                state_nxt = mem_ready_i ? RS1_W : RS1;
            end
            RS1_W: state_nxt = mem_rvalid_i ? (use_scalar_q ? WB : RS2) : RS1_W;
            RS2: begin
                mem_req_o = mem_ready_i;
                agu_get_rs2_o = mem_ready_i;
                state_nxt = mem_ready_i ? RS2_W : RS2;
            end
            RS2_W: state_nxt = mem_rvalid_i ? WB : RS2_W;
            WB: begin
                mem_req_o = mem_ready_i;
                mem_we_o = mem_ready_i;
                agu_get_rd_o = mem_ready_i;
                mem_wdata_o = alu_result_i;
                state_nxt = mem_ready_i ? ((cnt_inc == vl_q) ? DONE : RS1) : WB;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            vl_q <= '0;
            cnt <= '0;
            alu_op_a_o <= '0;
            alu_op_b_o <= '0;
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
            use_scalar_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_i) begin
                vl_q <= vl_i;
                cnt <= '0;
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
                use_scalar_q <= use_scalar_i;
                if (use_scalar_i) alu_op_b_o <= scalar_i;
`endif
            end
            if (state == RS1_W && mem_rvalid_i) alu_op_a_o <= mem_rdata_i;
            if (state == RS2_W && mem_rvalid_i) alu_op_b_o <= mem_rdata_i;
            if (state == WB && mem_ready_i) cnt <= cnt_inc;
        end
    end
endmodule

// File: tb/tb_vce2_vseq.sv
// tb_vce2_vseq: vector table plus hand sequences against a memory/AGU/ALU environment with a write scoreboard.
module tb_vce2_vseq;
    localparam int DW = 32;
    localparam int VW = 8;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start_i = 1'b0;
    logic [VW-1:0] vl_i = '0;
    logic busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, agu_get_rd_noincr_o;
    logic agu_ready_i = 1'b0;
    logic mem_ready_i = 1'b1;
    logic mem_req_o, mem_we_o, mem_rvalid_i;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i, alu_op_a_o, alu_op_b_o, alu_result_i;
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
    logic [DW-1:0] scalar_i = '0;
    logic use_scalar_i = 1'b0;
`endif
    typedef struct {logic [DW-1:0] a; logic [DW-1:0] b;} pair_t;
    typedef struct {int vl; int mode; int lat; int e1; int e2; int ew; int ed;} vec_t;
    pair_t sb[$];
    vec_t vt[6];
    int checks = 0, failures = 0;
    int rdy_mode = 0, lat = 1, agu_cnt = 0, pend_wait = 0, n_rs1 = 0, n_rs2 = 0, n_wr = 0;
    bit agu_armed = 0, pend = 0, parity = 0, sc_mode = 0, spur_rv = 0;
    logic rv_env = 1'b0;
    logic [DW-1:0] rd_env = '0, pend_data = '0, a_hold = '0, sc_val = '0, spur_data = '0;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a + {b[15:0], b[31:16]};
    endfunction

    assign alu_result_i = alu_f(alu_op_a_o, alu_op_b_o);
    assign mem_rvalid_i = rv_env | spur_rv;
    assign mem_rdata_i = spur_rv ? spur_data : rd_env;

    always #5 clk_i = ~clk_i;

    vce2_vseq #(.DataWidth(DW), .VlWidth(VW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .vl_i(vl_i),
`ifdef VCE2_VSEQ_SCALAR_OPB_EN
        .scalar_i(scalar_i), .use_scalar_i(use_scalar_i),
`endif
        .busy_o(busy_o), .done_o(done_o), .agu_load_o(agu_load_o), .agu_ready_i(agu_ready_i),
        .agu_get_rs1_o(agu_get_rs1_o), .agu_get_rs2_o(agu_get_rs2_o), .agu_get_rd_o(agu_get_rd_o),
        .agu_get_rd_noincr_o(agu_get_rd_noincr_o), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o),
        .alu_result_i(alu_result_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ctrl"}, {busy_o, done_o, agu_load_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o,
                              agu_get_rd_noincr_o, mem_req_o, mem_we_o}, 0);
        chk({name, "_op_a"}, alu_op_a_o, 0);
        chk({name, "_op_b"}, alu_op_b_o, 0);
        chk({name, "_wdata"}, mem_wdata_o, 0);
    endtask

    // Environment: AGU ready 3 cycles after load, memory with one read slot of latency lat.
    initial begin
        logic [DW-1:0] d;
        pair_t p;
        forever begin
            @(posedge clk_i);
            #1;
            if (agu_armed && agu_cnt < 3) agu_cnt++;
            agu_ready_i = agu_armed && agu_cnt >= 3;
            mem_ready_i = (rdy_mode == 2) ? 1'b0 : ((rdy_mode == 1) ? ~mem_ready_i : 1'b1);
            rv_env = 1'b0;
            if (pend) begin
                pend_wait--;
                if (pend_wait <= 0) begin
                    rv_env = 1'b1;
                    rd_env = pend_data;
                    pend = 0;
                end
            end
            @(negedge clk_i);
            if (agu_load_o) begin
                agu_armed = 1;
                agu_cnt = 0;
            end
            if (mem_req_o | mem_we_o | agu_get_rs1_o | agu_get_rs2_o | agu_get_rd_o) begin
                chk("strobes", {mem_req_o, agu_get_rd_noincr_o, agu_get_rs1_o, agu_get_rs2_o, agu_get_rd_o, mem_we_o},
                    mem_we_o ? 6'b100011 : ((parity == 0) ? 6'b101000 : 6'b100100));
                if (mem_we_o) begin
                    n_wr++;
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        p = sb.pop_front();
                        chk("wdata", mem_wdata_o, alu_f(p.a, p.b));
                        chk("wr_op_a", alu_op_a_o, p.a);
                        chk("wr_op_b", alu_op_b_o, p.b);
                    end
                end else begin
                    chk("one_outstanding", pend, 0);
                    d = $urandom;
                    pend = 1;
                    pend_wait = lat;
                    pend_data = d;
                    if (parity == 0) begin
                        n_rs1++;
                        if (sc_mode) sb.push_back('{a: d, b: sc_val});
                        else begin
                            a_hold = d;
                            parity = 1;
                        end
                    end else begin
                        n_rs2++;
                        sb.push_back('{a: a_hold, b: d});
                        parity = 0;
                    end
                end
            end
        end
    end

    task automatic wait_done(output int c);
        c = 1;
        forever begin
            @(negedge clk_i);
            if (done_o || c >= 400) break;
            c++;
            @(posedge clk_i);
            #1;
        end
        chk("done_seen", done_o, 1);
    endtask

    task automatic start_op(input int vl);
        n_rs1 = 0; n_rs2 = 0; n_wr = 0;
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        vl_i = VW'(vl);
        @(negedge clk_i);
        chk("load_pulse", agu_load_o, 1);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic finish_op(input int e1, input int e2, input int ew);
        chk("n_rs1", n_rs1, e1);
        chk("n_rs2", n_rs2, e2);
        chk("n_wr", n_wr, ew);
        chk("sb_empty", sb.size(), 0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("after_done", {done_o, busy_o, agu_load_o}, 0);
    endtask

    task automatic run_op(input int vl, input int mode, input int l, input int e1, input int e2, input int ew,
                          input int ed);
        int c;
        rdy_mode = mode;
        lat = l;
        start_op(vl);
        wait_done(c);
        if (ed >= 0) chk("done_cycle", c, ed);
        finish_op(e1, e2, ew);
    endtask

    task automatic wait_strobe(input bit rs2);
        int c = 0;
        forever begin
            @(negedge clk_i);
            if ((rs2 ? agu_get_rs2_o : agu_get_rs1_o) || c >= 100) break;
            c++;
            @(posedge clk_i);
            #1;
        end
        chk("strobe_seen", rs2 ? agu_get_rs2_o : agu_get_rs1_o, 1);
    endtask

    initial begin
        int c;
        vt[0] = '{vl: 4, mode: 0, lat: 1, e1: 4, e2: 4, ew: 4, ed: 24};
        vt[1] = '{vl: 0, mode: 0, lat: 1, e1: 0, e2: 0, ew: 0, ed: 4};
        vt[2] = '{vl: 2, mode: 1, lat: 3, e1: 2, e2: 2, ew: 2, ed: -1};
        vt[3] = '{vl: 1, mode: 0, lat: 1, e1: 1, e2: 1, ew: 1, ed: 9};
        vt[4] = '{vl: 3, mode: 0, lat: 2, e1: 3, e2: 3, ew: 3, ed: 25};
        vt[5] = '{vl: 5, mode: 1, lat: 1, e1: 5, e2: 5, ew: 5, ed: -1};
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk_idle("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++)
            run_op(vt[i].vl, vt[i].mode, vt[i].lat, vt[i].e1, vt[i].e2, vt[i].ew, vt[i].ed);

        // start_i during RS2_W and a spurious rvalid while WB is stalled
        rdy_mode = 0;
        lat = 3;
        start_op(1);
        wait_strobe(1);
        @(posedge clk_i);
        #1;
        start_i = 1'b1;
        @(negedge clk_i);
        chk("no_reload_1", agu_load_o, 0);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("no_reload_2", agu_load_o, 0);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("rs2_rvalid", mem_rvalid_i, 1);
        rdy_mode = 2;
        @(posedge clk_i);
        #1;
        spur_rv = 1;
        spur_data = 32'h5A5A_0F0F;
        @(negedge clk_i);
        chk("wb_stall", {busy_o, mem_req_o, agu_load_o}, 3'b100);
        chk("sb_pair", sb.size(), 1);
        if (sb.size() > 0) begin
            chk("spur_op_a", alu_op_a_o, sb[0].a);
            chk("spur_op_b", alu_op_b_o, sb[0].b);
        end
        rdy_mode = 0;
        @(posedge clk_i);
        #1;
        spur_rv = 0;
        wait_done(c);
        finish_op(1, 1, 1);

        // reset while a read is outstanding; the late response must be ignored
        rdy_mode = 0;
        lat = 3;
        start_op(1);
        wait_strobe(0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_idle("midrst");
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("late_rvalid", mem_rvalid_i, 1);
        chk_idle("late_rv");
        sb.delete();
        parity = 0;
        repeat (2) @(posedge clk_i);
        run_op(1, 0, 1, 1, 1, 1, 9);

`ifdef VCE2_VSEQ_SCALAR_OPB_EN
        sc_mode = 1;
        sc_val = 32'hDEAD_BEEF;
        scalar_i = 32'hDEAD_BEEF;
        use_scalar_i = 1'b1;
        run_op(3, 0, 1, 3, 0, 3, 13);
        chk("scalar_op_b", alu_op_b_o, 32'hDEAD_BEEF);
        sc_mode = 0;
        use_scalar_i = 1'b0;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
